// File: rtl/aes_req_scheduler.sv
// ---------------------------------------------------------------------------
// aes_req_scheduler
//
// Shares one fully pipelined, non-stallable AES-128 encryption core among
// NUM_REQ requesters. A round-robin arbiter issues at most one block per
// cycle into the core. A LATENCY-deep tag pipe carries {vld, id} alongside
// the block, so the core result can be pushed into a response FIFO together
// with its requester index. Issue is credit-gated: a block is only issued
// when (in_flight + fifo_count) < FIFO_DEPTH. Every result that leaves the
// core therefore has a FIFO slot, however long rsp_ready stays low.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   req_valid   [NUM_REQ]      per-requester request valid
//   req_ready   [NUM_REQ]      per-requester grant (one-hot or zero)
//   req_state   [NUM_REQ*128]  plaintexts, requester i at [128*i +: 128]
//   req_key     [NUM_REQ*128]  keys, same packing as req_state
//   core_state  [128]          plaintext to the core (0 when idle)
//   core_key    [128]          key to the core (0 when idle)
//   core_out    [128]          ciphertext from the core, LATENCY cycles later
//   rsp_valid                  response FIFO non-empty
//   rsp_ready                  consumer accepts the head response
//   rsp_data    [128]          ciphertext at the FIFO head
//   rsp_id      [IDW]          requester index at the FIFO head
//   busy                       blocks in flight or FIFO non-empty
// ---------------------------------------------------------------------------
module aes_req_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 32,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*128-1:0]   req_state,
    input  logic [NUM_REQ*128-1:0]   req_key,
    output logic [127:0]             core_state,
    output logic [127:0]             core_key,
    input  logic [127:0]             core_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [127:0]             rsp_data,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // Counts must be able to hold FIFO_DEPTH itself.
    localparam int CW = AW + 1;
    localparam logic [CW:0]    DEPTH_L = (CW+1)'(FIFO_DEPTH);
    localparam logic [IDW:0]   NREQ_L  = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  in_flight;
    logic [CW-1:0]  fifo_count;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic           can_issue;
    logic           grant;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand;
    logic           push;
    logic           pop;

    logic           vld_p [LATENCY];
    logic [IDW-1:0] id_p  [LATENCY];

    logic [127:0]   fifo_data [FIFO_DEPTH];
    logic [IDW-1:0] fifo_id   [FIFO_DEPTH];

    // Credits are judged on registered counts only, so a pop this cycle
    // frees a slot for issue in the next cycle.
    assign can_issue = ({1'b0, in_flight} + {1'b0, fifo_count}) < DEPTH_L;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
    // (NUM_REQ need not be a power of two, hence the explicit wrap).
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr} + (IDW+1)'(k);
                if (cand >= NREQ_L) begin
                    cand = cand - NREQ_L;
                end
                if (!grant && req_valid[cand[IDW-1:0]]) begin
                    grant   = 1'b1;
                    gnt_idx = cand[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Stage p0: granted block driven straight into the core; zero when idle.
    always_comb begin
        core_state = '0;
        core_key   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && gnt_idx == IDW'(i)) begin
                core_state = req_state[128*i +: 128];
                core_key   = req_key[128*i +: 128];
            end
        end
    end

    // Tag at the end of the pipe is aligned with core_out.
    assign push      = vld_p[LATENCY-1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = fifo_data[rd_ptr];
    assign rsp_id    = fifo_id[rd_ptr];
    assign busy      = (in_flight != '0) || rsp_valid;

    // Control state: arbiter pointer, tag valids, counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            if (grant) begin
                rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
            end
            vld_p[0] <= grant;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            in_flight  <= in_flight + CW'(grant) - CW'(push);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Stages p1..pLATENCY: tag ids and FIFO storage carry no reset; only the
    // valids above decide what they mean. A write to the slot being read
    // (full FIFO, push and pop together) is safe because the head is read
    // combinationally before the edge that overwrites it.
    always_ff @(posedge clk) begin
        id_p[0] <= gnt_idx;
        for (int i = 1; i < LATENCY; i++) begin
            id_p[i] <= id_p[i-1];
        end
        if (push) begin
            fifo_data[wr_ptr] <= core_out;
            fifo_id[wr_ptr]   <= id_p[LATENCY-1];
        end
    end

endmodule
